fp16_accum_ctrl: RTL and testbench

FP16_ACCUM_CTRL -- requirements
Module: fp16_accum_ctrl

---
 rtl/fp16_accum_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fp16_accum_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accum_ctrl.sv
// FP16 packet accumulator: sums the beats of each in_last-delimited packet with one FP16 adder.
// Optional out_count port (beat count of the packet) is enabled by defining FP16_ACCUM_COUNT_EN.

module FP16adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);
  logic        x_is_a, sx, sy, eff_sub, rnd_up;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [4:0]  ex, ey, e_field;
  logic [5:0]  ex_eff, ey_eff, d, e_n, sh;
  logic [10:0] mx, my;
  logic [26:0] yw;
  logic [13:0] xsh, ysh, n;
  logic [14:0] s;
  logic [3:0]  lz;
  logic [15:0] rounded;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    sh      = '0;
    n       = '0;
    e_n     = '0;
    lz      = 4'd14;
    result  = '0;

    // Order operands by magnitude so the aligned difference can never go negative.
    x_is_a  = a[14:0] >= b[14:0];
    sx      = x_is_a ? a[15]     : b[15];
    sy      = x_is_a ? b[15]     : a[15];
    ex      = x_is_a ? a[14:10]  : b[14:10];
    ey      = x_is_a ? b[14:10]  : a[14:10];
    mx      = {ex != 5'd0, x_is_a ? a[9:0] : b[9:0]};
    my      = {ey != 5'd0, x_is_a ? b[9:0] : a[9:0]};
    ex_eff  = (ex == 5'd0) ? 6'd1 : {1'b0, ex};
    ey_eff  = (ey == 5'd0) ? 6'd1 : {1'b0, ey};
    d       = ex_eff - ey_eff;

    // Three extra bits below the mantissa: guard, round, sticky.
    yw      = {my, 16'b0} >> d;
    ysh     = (d > 6'd26) ? {13'b0, |my} : {yw[26:14], |yw[13:0]};
    xsh     = {mx, 3'b000};
    eff_sub = sx ^ sy;
    s       = eff_sub ? {1'b0, xsh - ysh} : ({1'b0, xsh} + {1'b0, ysh});

    for (int i = 0; i < 14; i++)
      if (s[i]) lz = 4'(13 - i);

    if (s[14]) begin
      n   = {s[14:2], s[1] | s[0]};
      e_n = ex_eff + 6'd1;
    end else begin
      // Stop the left shift at the subnormal boundary.
      sh  = (6'(lz) < ex_eff) ? 6'(lz) : ex_eff - 6'd1;
      n   = s[13:0] << sh;
      e_n = ex_eff - sh;
    end

    e_field = n[13] ? e_n[4:0] : 5'd0;
    rnd_up  = n[2] & (n[1] | n[0] | n[3]);
    // Mantissa carry ripples into the exponent field, covering subnormal->normal and overflow to Inf.
    rounded = {1'b0, e_field, n[12:3]} + 16'(rnd_up);

    if (s == 15'd0)
      result = {sx & sy, 15'd0};
    else if (e_n >= 6'd31)
      result = {sx, 5'h1F, 10'h000};
    else
      result = {sx, rounded[14:0]};

    a_nan = (&a[14:10]) && (|a[9:0]);
    b_nan = (&b[14:10]) && (|b[9:0]);
    a_inf = (&a[14:10]) && !(|a[9:0]);
    b_inf = (&b[14:10]) && !(|b[9:0]);
    if (a_nan)
      result = a | 16'h0200;
    else if (b_nan)
      result = b | 16'h0200;
    else if (a_inf && b_inf && (a[15] != b[15]))
      result = 16'h7E00;
    else if (a_inf)
      result = a;
    else if (b_inf)
      result = b;
  end
endmodule

module fp16_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
`ifdef FP16_ACCUM_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d, sum;
  logic        accept;

  FP16adder u_add (
    .a      (acc_q),
    .b      (in_data),
    .result (sum)
  );

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == ACC);
  assign out_data  = acc_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: if (accept) begin
        acc_d   = in_data;
        state_d = in_last ? OUT : ACC;
      end
      ACC: if (accept) begin
        acc_d   = sum;
        state_d = in_last ? OUT : ACC;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

`ifdef FP16_ACCUM_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // First beat restarts the count; later beats saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= (state_q == IDLE) ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + CNT_W'(1));
  end

  assign out_count = cnt;
`endif
endmodule

// File: tb/tb_fp16_accum_ctrl.sv
// Self-checking bench for fp16_accum_ctrl: scoreboard of expected packet sums popped on output handshakes.
`timescale 1ns/1ps
module tb_fp16_accum_ctrl;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;
`ifdef FP16_ACCUM_COUNT_EN
  logic [CNT_W-1:0] out_count;
`endif

  typedef struct {
    logic [15:0] data;
    int          count;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cycles = 0;

  fp16_accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FP16_ACCUM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every handshake must match the oldest expected packet.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum", 32'(out_data), 32'(e.data));
`ifdef FP16_ACCUM_COUNT_EN
        check("count", 32'(out_count), 32'(e.count));
`endif
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [15:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("beat_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input logic [15:0] beats[$], input logic [15:0] sum);
    exp_t e;
    e.data  = sum;
    e.count = (beats.size() > CNT_MAX) ? CNT_MAX : beats.size();
    sb_q.push_back(e);
    for (int i = 0; i < beats.size(); i++)
      send(beats[i], i == beats.size() - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] pkt[$];

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(out_data), 32'h0000);
`ifdef FP16_ACCUM_COUNT_EN
    check("rst_count", 32'(out_count), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 + 2.0: sum visible the cycle right after the last beat, input blocked meanwhile.
    pkt = '{16'h3C00, 16'h4000};
    send_packet(pkt, 16'h4200);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("out_blocks_in", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle_after_hs", 32'(out_valid), 32'd0);

    // 1 + 2 + 1 = 4 with back-to-back beats; busy for exactly two cycles.
    busy_cycles = 0;
    pkt = '{16'h3C00, 16'h4000, 16'h3C00};
    send_packet(pkt, 16'h4400);
    check("busy_in_out", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("busy_cycles", 32'(busy_cycles), 32'd2);

    // Single beat returns the operand bit-exactly.
    pkt = '{16'hC500};
    send_packet(pkt, 16'hC500);
    @(posedge clk);
    #1;

    // Assorted sums: halves, cancellation to 1.0, infinity propagation.
    pkt = '{16'h3800, 16'h3800};
    send_packet(pkt, 16'h3C00);
    @(posedge clk);
    #1;
    pkt = '{16'h4200, 16'hC000};
    send_packet(pkt, 16'h3C00);
    @(posedge clk);
    #1;
    pkt = '{16'h7C00, 16'h3C00};
    send_packet(pkt, 16'h7C00);
    @(posedge clk);
    #1;

    // Consumer stalls for 5 cycles while a stray beat is offered.
    out_ready = 1'b0;
    pkt = '{16'h3C00, 16'h3C00};
    send_packet(pkt, 16'h4000);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h4000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_released", 32'(out_valid), 32'd0);
    pkt = '{16'h4400};
    send_packet(pkt, 16'h4400);
    @(posedge clk);
    #1;

    // Reset mid-packet discards the partial sum.
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_acc", 32'(out_data), 32'h0000);
`ifdef FP16_ACCUM_COUNT_EN
    check("mid_rst_count", 32'(out_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pkt = '{16'h4000};
    send_packet(pkt, 16'h4000);
    @(posedge clk);
    #1;

    // Five zero beats: count saturates at 3, sum stays zero.
    pkt = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    send_packet(pkt, 16'h0000);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++)
      @(posedge clk);
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
